// File: rtl/tracker_pkg.sv
// Shared types and constants for the tracker axis drivers: direction codes,
// stepper FSM state encoding and the half-step coil phase table.
package tracker_pkg;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_CW   = 2'b01;
    localparam logic [1:0] DIR_CCW  = 2'b11;
    localparam logic [1:0] DIR_BAD  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_REVERSE = 2'd2,
        ST_HOLD    = 2'd3
    } step_state_e;

    // {A,B,A_n,B_n} per phase, phase 0 in the least significant nibble
    localparam logic [31:0] PHASE_TBL = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                         4'b0110, 4'b0100, 4'b1100, 4'b1000};

    function automatic logic [3:0] phase_coil(input logic [2:0] phase);
        return PHASE_TBL[{phase, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/stepper_phase_driver_if.sv
// Command/status bundle between the motion controller and one stepper axis driver.
interface stepper_phase_driver_if;
    import tracker_pkg::*;

    logic        en;
    logic [1:0]  dir_cmd;
    logic        pos_load;
    logic [15:0] pos_load_val;
    logic [3:0]  coil;
    logic [15:0] pos_actual;
    logic        busy;
    logic        at_limit;
    logic        fault;

    modport master (
        output en, dir_cmd, pos_load, pos_load_val,
        input  coil, pos_actual, busy, at_limit, fault
    );

    modport slave (
        input  en, dir_cmd, pos_load, pos_load_val,
        output coil, pos_actual, busy, at_limit, fault
    );

endinterface

// File: rtl/stepper_phase_driver_step_tick_gen.sv
// Free-running divide-by-DIV counter with synchronous clear; tick_c marks the last count.
module step_tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;

    assign tick_c = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/stepper_phase_driver.sv
// One-axis stepper driver: direction code in, timed coil phase sequence and
// soft-limited position count out.
module stepper_phase_driver
    import tracker_pkg::*;
#(
    parameter int unsigned STEP_DIV    = 50000,
    parameter int unsigned HOLD_CYCLES = 250000,
    parameter logic [15:0] POS_MIN     = 16'd0,
    parameter logic [15:0] POS_MAX     = 16'd3600,
    parameter bit          HALF_STEP   = 1'b1
) (
    input logic                   clk,
    input logic                   rst_n,
    stepper_phase_driver_if.slave bus
);

    localparam int unsigned HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [2:0]  PH_STEP = HALF_STEP ? 3'd1 : 3'd2;

    step_state_e   state_q, state_n;
    logic [1:0]    dir_q, dir_n;
    logic [2:0]    phase_q, phase_n;
    logic [15:0]   pos_q, pos_n;
    logic [HW-1:0] hold_q, hold_n;
    logic [3:0]    coil_q;
    logic          busy_q, at_limit_q, fault_q;
    logic          legal_c, step_c, tick_c, tick_clr_c;

    function automatic logic [15:0] clamp_pos(input logic [15:0] v);
        if (v <= POS_MIN) return POS_MIN;
        if (v >= POS_MAX) return POS_MAX;
        return v;
    endfunction

    step_tick_gen #(.DIV(STEP_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tick_clr_c),
        .tick_c (tick_c)
    );

    // Next-state, phase and position logic
    always_comb begin
        state_n = state_q;
        dir_n   = dir_q;
        phase_n = phase_q;
        pos_n   = pos_q;
        hold_n  = '0;
        step_c  = 1'b0;
        legal_c = (bus.dir_cmd == DIR_CW) || (bus.dir_cmd == DIR_CCW);

        unique case (state_q)
            ST_IDLE: begin
                if (legal_c) begin
                    state_n = ST_RUN;
                    dir_n   = bus.dir_cmd;
                end
            end
            ST_RUN: begin
                if (!legal_c)                   state_n = ST_HOLD;
                else if (bus.dir_cmd != dir_q)  state_n = ST_REVERSE;
                else if (tick_c)                step_c  = 1'b1;
            end
            ST_REVERSE: begin
                if (!legal_c) begin
                    state_n = ST_HOLD;
                end else if (bus.dir_cmd == dir_q) begin
                    state_n = ST_RUN;
                end else if (tick_c) begin
                    state_n = ST_RUN;
                    dir_n   = bus.dir_cmd;
                end
            end
            ST_HOLD: begin
                if (legal_c) begin
                    state_n = (bus.dir_cmd == dir_q) ? ST_RUN : ST_REVERSE;
                end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                end else begin
                    hold_n = hold_q + HW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Steps into a soft limit are swallowed; the tick counter keeps cycling
        if (step_c) begin
            if (dir_q == DIR_CW && pos_q != POS_MAX) begin
                phase_n = phase_q + PH_STEP;
                pos_n   = pos_q + 16'd1;
            end else if (dir_q == DIR_CCW && pos_q != POS_MIN) begin
                phase_n = phase_q - PH_STEP;
                pos_n   = pos_q - 16'd1;
            end
        end

        if (!bus.en) begin
            state_n = ST_IDLE;
            dir_n   = dir_q;
            phase_n = phase_q;
            pos_n   = pos_q;
            hold_n  = '0;
        end

        // A preset load overrides any coincident step
        if (bus.pos_load) begin
            pos_n   = clamp_pos(bus.pos_load_val);
            phase_n = phase_q;
        end

        tick_clr_c = (state_n != state_q) ||
                     !((state_n == ST_RUN) || (state_n == ST_REVERSE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_STOP;
            phase_q    <= '0;
            pos_q      <= POS_MIN;
            hold_q     <= '0;
            coil_q     <= '0;
            busy_q     <= 1'b0;
            at_limit_q <= 1'b1;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            dir_q      <= dir_n;
            phase_q    <= phase_n;
            pos_q      <= pos_n;
            hold_q     <= hold_n;
            coil_q     <= (state_n == ST_IDLE) ? 4'b0000 : phase_coil(phase_n);
            busy_q     <= (state_n == ST_RUN) || (state_n == ST_REVERSE);
            at_limit_q <= (pos_n == POS_MIN) || (pos_n == POS_MAX);
            fault_q    <= bus.en ? (fault_q || (bus.dir_cmd == DIR_BAD)) : 1'b0;
        end
    end

    assign bus.coil       = coil_q;
    assign bus.pos_actual = pos_q;
    assign bus.busy       = busy_q;
    assign bus.at_limit   = at_limit_q;
    assign bus.fault      = fault_q;

endmodule
